// File: rtl/music_mode_ctrl.sv
// Play-mode controller: debounced buttons, FREE/AUTO/LEARN mode FSM, song select and buzzer arbitration.
// Optional: define MUSIC_AUTO_ADVANCE_EN to let song_end advance the song while in AUTO.
module music_btn_db #(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_ok,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2, acc, armed;
  logic [CW-1:0] cnt;

  // armed only after a genuine released level has been seen, so a button
  // held across reset never produces a press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      acc   <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      armed <= armed | (sync_ok & ~s2);
      if (s2 == acc) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        acc   <= s2;
        cnt   <= '0;
        press <= s2 & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module music_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int NUM_SONGS       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic [6:0]  key_notes,
  input  logic [31:0] key_freq,
  input  logic [31:0] player_freq,
  input  logic [6:0]  expected_lights,
  input  logic        song_end,
  output logic [1:0]  mode,
  output logic [1:0]  present_song,
  output logic        modechange,
  output logic        is_auto,
  output logic        is_match,
  output logic [31:0] buzzer_freq
);
  typedef enum logic [1:0] {FREE = 2'd0, AUTO = 2'd1, LEARN = 2'd2, BAD = 2'd3} mode_e;
  localparam logic [1:0] LAST_SONG = 2'(NUM_SONGS - 1);

  mode_e      mode_q, mode_d;
  logic [1:0] song_q, song_d, song_inc, song_dec;
  logic       mc_d;
  logic [1:0] ok_q;
  logic [2:0] raw, press;

  assign raw = {btn_prev, btn_next, btn_mode};

  // marks when the synchronizers hold real input samples after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ok_q <= '0;
    else        ok_q <= {ok_q[0], 1'b1};
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    music_btn_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .sync_ok(ok_q[1]), .raw(raw[i]), .press(press[i])
    );
  end

`ifndef MUSIC_AUTO_ADVANCE_EN
  logic unused_song_end;
  assign unused_song_end = song_end;
`endif

  assign song_inc = (song_q == LAST_SONG) ? 2'd0 : song_q + 2'd1;
  assign song_dec = (song_q == 2'd0) ? LAST_SONG : song_q - 2'd1;

  always_comb begin
    mode_d = mode_q;
    song_d = song_q;
    mc_d   = 1'b0;
    if (press[0] || mode_q == BAD) begin
      mc_d   = 1'b1;
      song_d = 2'd0;
      case (mode_q)
        FREE:    mode_d = AUTO;
        AUTO:    mode_d = LEARN;
        default: mode_d = FREE;
      endcase
    end else if (mode_q != FREE && press[1]) begin
      song_d = song_inc;
    end else if (mode_q != FREE && press[2]) begin
      song_d = song_dec;
`ifdef MUSIC_AUTO_ADVANCE_EN
    end else if (mode_q == AUTO && song_end) begin
      song_d = song_inc;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= FREE;
      song_q      <= 2'd0;
      modechange  <= 1'b0;
      is_auto     <= 1'b0;
      is_match    <= 1'b0;
      buzzer_freq <= '0;
    end else begin
      mode_q     <= mode_d;
      song_q     <= song_d;
      modechange <= mc_d;
      is_auto    <= (mode_d == AUTO);
      is_match   <= (mode_q == LEARN) &&
                    (expected_lights == 7'd0 || key_notes == expected_lights);
      // LEARN gates on the registered match, hence one extra cycle there
      case (mode_q)
        FREE:    buzzer_freq <= key_freq;
        AUTO:    buzzer_freq <= player_freq;
        LEARN:   buzzer_freq <= is_match ? player_freq : 32'd0;
        default: buzzer_freq <= 32'd0;
      endcase
    end
  end

  assign mode         = mode_q;
  assign present_song = song_q;
endmodule
